// File: rtl/pulse_pkg.sv
// Shared types and default constants for the pulse pin conditioning blocks.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW    = 2'd0,
    QUAL_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    QUAL_LOW    = 2'd3
  } pulse_state_e;

  localparam int PULSE_SYNC_STAGES     = 2;
  localparam int PULSE_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/pulse_sync.sv
// Multi-flop synchronizer for a single asynchronous pin; STAGES must be 2..4.
module pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the pin through the chain; bit 0 is the metastability-exposed stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chain <= {STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pulse_debounce_edge.sv
// Pulse pin front end: synchronize, qualify level changes over DEBOUNCE_CYCLES
// samples, and emit a clean level, rise/fall strobes and a saturating glitch tally.
module pulse_debounce_edge
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = PULSE_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = PULSE_DEBOUNCE_CYCLES,
  parameter int GLITCH_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pulse_async,
  input  logic                en,
  output logic                pulse_clean,
  output logic                o_rise,
  output logic                o_fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int                  CNT_W         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX    = {GLITCH_W{1'b1}};
  localparam logic [GLITCH_W-1:0] GLITCH_ONE    = GLITCH_W'(1);
  localparam logic                SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);

  logic                w_s;
  pulse_state_e        r_state;
  pulse_state_e        w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_glitch_inc;
  logic                w_rise_nxt;
  logic                w_fall_nxt;
  logic                r_clean;
  logic                r_rise;
  logic                r_fall;
  logic                r_busy;
  logic [GLITCH_W-1:0] r_glitch;

  pulse_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (pulse_async),
    .o_q  (w_s)
  );

  // Next-state logic; the qual counter is zero whenever no qualification is running.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = CNT_ZERO;
    w_glitch_inc = 1'b0;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (en && w_s) begin
          if (SINGLE_SAMPLE) begin
            w_state_nxt = STABLE_HIGH;
            w_rise_nxt  = 1'b1;
          end else begin
            w_state_nxt = QUAL_HIGH;
            w_cnt_nxt   = CNT_ONE;
          end
        end else begin
          w_state_nxt = IDLE_LOW;
        end
      end
      QUAL_HIGH: begin
        // en is checked first so a disable never counts as a glitch.
        if (!en) begin
          w_state_nxt = IDLE_LOW;
        end else if (!w_s) begin
          w_state_nxt  = IDLE_LOW;
          w_glitch_inc = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HIGH;
          w_rise_nxt  = 1'b1;
        end else begin
          w_state_nxt = QUAL_HIGH;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (en && !w_s) begin
          if (SINGLE_SAMPLE) begin
            w_state_nxt = IDLE_LOW;
            w_fall_nxt  = 1'b1;
          end else begin
            w_state_nxt = QUAL_LOW;
            w_cnt_nxt   = CNT_ONE;
          end
        end else begin
          w_state_nxt = STABLE_HIGH;
        end
      end
      QUAL_LOW: begin
        if (!en) begin
          w_state_nxt = STABLE_HIGH;
        end else if (w_s) begin
          w_state_nxt  = STABLE_HIGH;
          w_glitch_inc = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_fall_nxt  = 1'b1;
        end else begin
          w_state_nxt = QUAL_LOW;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
      end
    endcase
  end

  // State, counters and outputs all register together so they stay cycle-aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE_LOW;
      r_cnt    <= CNT_ZERO;
      r_clean  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_busy   <= 1'b0;
      r_glitch <= {GLITCH_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_clean <= (w_state_nxt == STABLE_HIGH) || (w_state_nxt == QUAL_LOW);
      r_busy  <= (w_state_nxt == QUAL_HIGH) || (w_state_nxt == QUAL_LOW);
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      if (w_glitch_inc && (r_glitch != GLITCH_MAX)) begin
        r_glitch <= r_glitch + GLITCH_ONE;
      end
    end
  end

  assign pulse_clean = r_clean;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign busy        = r_busy;
  assign glitch_cnt  = r_glitch;

endmodule

// File: tb/tb_pulse_debounce_edge.sv
// Scoreboard bench for pulse_debounce_edge: three configurations share one stimulus
// stream and are compared every cycle against a run-length reference model.
module tb_pulse_debounce_edge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse_async = 1'b0;
  logic en = 1'b0;

  logic a_clean, a_rise, a_fall, a_busy;
  logic [15:0] a_glitch;
  logic b_clean, b_rise, b_fall, b_busy;
  logic [1:0] b_glitch;
  logic c_clean, c_rise, c_fall, c_busy;
  logic [3:0] c_glitch;

  always #5 clk = ~clk;

  pulse_debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .pulse_async(pulse_async), .en(en),
    .pulse_clean(a_clean), .o_rise(a_rise), .o_fall(a_fall), .busy(a_busy),
    .glitch_cnt(a_glitch));

  pulse_debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .GLITCH_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pulse_async(pulse_async), .en(en),
    .pulse_clean(b_clean), .o_rise(b_rise), .o_fall(b_fall), .busy(b_busy),
    .glitch_cnt(b_glitch));

  pulse_debounce_edge #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .GLITCH_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .pulse_async(pulse_async), .en(en),
    .pulse_clean(c_clean), .o_rise(c_rise), .o_fall(c_fall), .busy(c_busy),
    .glitch_cnt(c_glitch));

  typedef struct packed {
    logic [3:0]  f0, f1, f2;   // {clean, rise, fall, busy}
    logic [15:0] g0, g1, g2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: pin history plus, per config, accepted level and run length
  int m_sync[3]  = '{2, 2, 3};
  int m_deb[3]   = '{4, 4, 1};
  int m_gmax[3]  = '{65535, 3, 15};
  bit m_clean[3];
  bit m_rise[3];
  bit m_fall[3];
  int m_run[3];
  int m_glitch[3];
  bit pin_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic p, input logic e);
    bit s[3];
    if (!r) begin
      pin_hist.delete();
      for (int i = 0; i < 3; i++) begin
        m_clean[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
        m_run[i] = 0; m_glitch[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        s[i] = (pin_hist.size() >= m_sync[i]) ? pin_hist[m_sync[i]-1] : 1'b0;
      end
      pin_hist.push_front(p);
      if (pin_hist.size() > 8) void'(pin_hist.pop_back());
      for (int i = 0; i < 3; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (!e) begin
          m_run[i] = 0;
        end else if (s[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == m_deb[i]) begin
            m_clean[i] = s[i];
            if (s[i]) m_rise[i] = 1'b1;
            else      m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          if (m_run[i] > 0 && m_glitch[i] < m_gmax[i]) m_glitch[i]++;
          m_run[i] = 0;
        end
      end
    end
  endtask

  function automatic exp_t pack_exp();
    exp_t x;
    x.f0 = {m_clean[0], m_rise[0], m_fall[0], m_run[0] > 0};
    x.f1 = {m_clean[1], m_rise[1], m_fall[1], m_run[1] > 0};
    x.f2 = {m_clean[2], m_rise[2], m_fall[2], m_run[2] > 0};
    x.g0 = 16'(m_glitch[0]);
    x.g1 = 16'(m_glitch[1]);
    x.g2 = 16'(m_glitch[2]);
    return x;
  endfunction

  task automatic step(input logic r, input logic p, input logic e);
    rst_n = r;
    pulse_async = p;
    en = e;
    @(posedge clk);
    model_step(r, p, e);
    exp_q.push_back(pack_exp());
    #1;
  endtask

  // Monitor: every cycle the DUTs present their outputs; compare against the queue head
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("A_outputs", 32'({a_clean, a_rise, a_fall, a_busy, a_glitch}), 32'({x.f0, x.g0}));
      check("B_outputs", 32'({b_clean, b_rise, b_fall, b_busy, 16'(b_glitch)}), 32'({x.f1, x.g1}));
      check("C_outputs", 32'({c_clean, c_rise, c_fall, c_busy, 16'(c_glitch)}), 32'({x.f2, x.g2}));
      check("A_strobe_excl", 32'(a_rise & a_fall), 32'd0);
    end
  end

  int   rise_at;
  int   busy_n;
  logic pin_v;
  logic en_v;
  logic rst_v;
  int   run_left;

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("reset_clean", 32'(a_clean), 32'd0);
    check("reset_glitch", 32'(a_glitch), 32'd0);

    // Steady high pin: rise after SYNC_STAGES+D edges, busy for D-1 cycles
    repeat (9) step(1'b1, 1'b0, 1'b1);
    rise_at = -1;
    busy_n = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, 1'b1);
      if (a_rise && rise_at < 0) rise_at = k;
      if (a_busy) busy_n++;
    end
    check("t1_rise_edge", 32'(rise_at), 32'd6);
    check("t1_busy_cycles", 32'(busy_n), 32'd3);
    check("t1_clean", 32'(a_clean), 32'd1);

    // Three-sample pulse is rejected as a glitch
    step(1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    repeat (8) step(1'b1, 1'b0, 1'b1);
    check("t2_clean", 32'(a_clean), 32'd0);
    check("t2_glitch", 32'(a_glitch), 32'd1);

    // Clean high then low
    repeat (20) step(1'b1, 1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0, 1'b1);
    check("t3_clean_low", 32'(a_clean), 32'd0);

    // en dropped mid-qualification, then restored with pin held high
    repeat (4) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    rise_at = -1;
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b1, 1'b1);
      if (a_rise && rise_at < 0) rise_at = k;
    end
    check("t4_rise_after_en", 32'(rise_at), 32'd4);
    check("t4_glitch_same", 32'(a_glitch), 32'd1);

    // Reset while qualifying low
    repeat (3) step(1'b1, 1'b0, 1'b1);
    check("t5_busy_before", 32'(a_busy), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("t5_after_reset", 32'({a_clean, a_rise, a_fall, a_busy}), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check("t5_no_fall", 32'(a_fall), 32'd0);

    // Five single-cycle glitches saturate the 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0, 1'b1);
      check("t6_sat_glitch", 32'(b_glitch), (k < 3) ? 32'(k) : 32'd3);
    end
    check("t6_wide_glitch", 32'(a_glitch), 32'd5);

    // Randomized runs including every-cycle toggling, en drops and rare resets
    pin_v = 1'b0;
    run_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (run_left == 0) begin
        pin_v = ~pin_v;
        run_left = (n < 200) ? 1 : $urandom_range(1, 9);
      end
      run_left--;
      en_v  = ($urandom_range(0, 19) != 0);
      rst_v = ($urandom_range(0, 399) != 0);
      step(rst_v, pin_v, en_v);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_debounce_edge.md
Name: pulse_debounce_edge

Overview:
- Front-end conditioning stage for an external, asynchronous pulse pin.
- Synchronizes the pin into clk, rejects glitches shorter than a programmable number of cycles, and outputs a clean level plus single-cycle rise/fall strobes.
- pulse_clean / o_rise feed the pulse counter directly, so the counter only ever sees debounced edges.
- Also keeps a saturating count of rejected glitches for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive identical synchronized samples needed to accept a level change; legal minimum 1.
- GLITCH_W, 16, width of the glitch counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pulse_async  in  1  raw pin, asynchronous to clk.
- en  in  1  qualification enable; the synchronizer runs regardless of en.
- pulse_clean  out  1  debounced level.
- o_rise  out  1  one-cycle strobe when pulse_clean goes 0->1.
- o_fall  out  1  one-cycle strobe when pulse_clean goes 1->0.
- busy  out  1  high while in QUAL_HIGH or QUAL_LOW.
- glitch_cnt  out  GLITCH_W  number of rejected qualifications, saturating.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge): sync chain=0, state=IDLE_LOW, qual counter=0, all outputs=0, glitch_cnt=0. Reset mid-qualification aborts it: no strobe, no glitch count.
- Synchronizer: s = last stage of the chain. If pulse_async is high when sampled at edge t, s is high from cycle t+SYNC_STAGES.
- States: IDLE_LOW (clean=0), QUAL_HIGH, STABLE_HIGH (clean=1), QUAL_LOW. Let D = DEBOUNCE_CYCLES; qual counter is $clog2(D+1) bits.
- IDLE_LOW:
  - s=1 and D==1: go to STABLE_HIGH.
  - s=1 and D>1: go to QUAL_HIGH with cnt=1.
  - Otherwise stay.
- QUAL_HIGH:
  - s=0: go to IDLE_LOW and increment glitch_cnt.
  - s=1 and cnt==D-1: go to STABLE_HIGH.
  - Otherwise cnt++.
- STABLE_HIGH and QUAL_LOW mirror IDLE_LOW and QUAL_HIGH with s inverted. Acceptance goes to IDLE_LOW.
- Outputs are registered with state:
  - pulse_clean=1 exactly in STABLE_HIGH and QUAL_LOW.
  - o_rise=1 for exactly the first cycle of STABLE_HIGH entered from IDLE_LOW or QUAL_HIGH.
  - o_fall=1 for exactly the first cycle of IDLE_LOW entered from STABLE_HIGH or QUAL_LOW.
- Latency: if s first goes high in cycle k (state IDLE_LOW) and stays high, pulse_clean and o_rise are high in cycle k+D. Pin-to-o_rise latency is SYNC_STAGES+D cycles; the falling direction is symmetric.
- Strobe spacing: o_rise and o_fall are never high in the same cycle. Minimum spacing between opposite strobes is D cycles.
- en=0:
  - QUAL_HIGH returns to IDLE_LOW; QUAL_LOW returns to STABLE_HIGH.
  - cnt is cleared, no glitch is counted, and no strobes are generated.
  - pulse_clean holds its accepted value.
  - Qualification restarts from zero on the first cycle with en=1.
- glitch_cnt saturates at all ones and is cleared only by reset. A glitch and an en drop in the same cycle: en wins, nothing is counted.
- Pin toggling every cycle: no state change ever reaches STABLE; glitch_cnt increments once per aborted qualification.

Decomposition:
- Shared package pulse_pkg:
  - state enum (IDLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW);
  - default constants PULSE_SYNC_STAGES=2 and PULSE_DEBOUNCE_CYCLES=16.
- One sub-module, pulse_sync: SYNC_STAGES-deep flop chain with synchronous reset, reusable by other pin inputs.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=16):
1. Reset, then pulse_async=1 sampled from edge 10 onward with en=1 -> o_rise high only in cycle 16; pulse_clean=1 from cycle 16; busy high in cycles 13-15.
2. pulse_async held high for 3 sampled cycles then low, en=1 -> no o_rise; pulse_clean stays 0; glitch_cnt=1.
3. Clean high for 20 cycles, then low -> one o_rise, then one o_fall 6 cycles after the first low sample; pulse_clean back to 0.
4. en dropped to 0 during QUAL_HIGH (cnt=2) -> state returns to IDLE_LOW; glitch_cnt unchanged. After en=1 with the pin still high, o_rise comes 4 cycles later.
5. rst_n=0 for one edge while in QUAL_LOW with pulse_clean=1 -> next cycle all outputs 0, state IDLE_LOW, no o_fall.
6. GLITCH_W=2, five 1-cycle glitches -> glitch_cnt goes 1, 2, 3, 3, 3 (saturates).
